// File: rtl/fwd_source_pipe.sv
// fwd_source_pipe: MEM/WB back half of the 5-stage pipeline with forwarding bundles.
// Define FWD_WB_BYPASS_EN to drive ALUres_wb from the WB stage; otherwise it reads 0.
module fwd_source_pipe #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    input  logic [31:0]            ex_alu_res,
    input  logic [31:0]            ex_store_data,
    input  logic [4:0]             ex_wr_addr,
    input  logic                   ex_regWr,
    input  logic                   ex_memToReg,
    input  logic                   ex_memWr,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [31:0]            dmem_rdata,
    output logic [31:0]            dmem_addr,
    output logic [31:0]            dmem_wdata,
    output logic                   dmem_we,
    output logic [37:0]            ALUres_ex,
    output logic [37:0]            ALUres_mem,
    output logic [37:0]            ALUres_wb,
    output logic [31:0]            dw,
    output logic [4:0]             wr_addr,
    output logic                   wr_en,
    output logic                   load_stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                   mem_valid;
    logic [31:0]            mem_res;
    logic [31:0]            mem_sdata;
    logic [4:0]             mem_addr;
    logic                   mem_regWr;
    logic                   mem_memToReg;
    logic                   mem_memWr;

    logic                   wb_valid;
    logic [31:0]            wb_data;
    logic [4:0]             wb_addr;
    logic                   wb_regWr;

    logic [STALL_CNT_W-1:0] stall_cnt;

    logic                   ew_ex;
    logic                   ew_mem;
    logic                   ew_wb;
    logic [31:0]            mem_data;
    logic                   rd_hit;

    // Effective writes: only valid, register-writing, non-$0 destinations count.
    always_comb begin
        ew_ex    = ex_valid & ex_regWr & (ex_wr_addr != 5'd0);
        ew_mem   = mem_valid & mem_regWr & (mem_addr != 5'd0);
        ew_wb    = wb_valid & wb_regWr & (wb_addr != 5'd0);
        mem_data = mem_memToReg ? dmem_rdata : mem_res;
        rd_hit   = (ex_wr_addr == id_rs) | (ex_wr_addr == id_rt);
    end

    // Load-use hazard: load result is not ready until the MEM stage.
    always_comb begin
        load_stall = ew_ex & ex_memToReg & rd_hit;
    end

    // Forwarding bundles and memory / regfile port drive.
    always_comb begin
        ALUres_ex  = {ew_ex & ~ex_memToReg, ex_wr_addr, ex_alu_res};
        ALUres_mem = {ew_mem, mem_addr, mem_data};
`ifdef FWD_WB_BYPASS_EN
        ALUres_wb  = {ew_wb, wb_addr, wb_data};
`else
        ALUres_wb  = 38'b0;
`endif
        dmem_addr   = mem_res;
        dmem_wdata  = mem_sdata;
        dmem_we     = mem_valid & mem_memWr;
        dw          = wb_data;
        wr_addr     = wb_addr;
        wr_en       = ew_wb;
        stall_count = stall_cnt;
    end

    // EX -> MEM register; bubbles carry no write, store or load side effects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid    <= 1'b0;
            mem_res      <= 32'd0;
            mem_sdata    <= 32'd0;
            mem_addr     <= 5'd0;
            mem_regWr    <= 1'b0;
            mem_memToReg <= 1'b0;
            mem_memWr    <= 1'b0;
        end else begin
            mem_valid    <= ex_valid;
            mem_res      <= ex_alu_res;
            mem_sdata    <= ex_store_data;
            mem_addr     <= ex_wr_addr;
            mem_regWr    <= ex_valid & ex_regWr;
            mem_memToReg <= ex_valid & ex_memToReg;
            mem_memWr    <= ex_valid & ex_memWr;
        end
    end

    // MEM -> WB register; loads capture the memory read data here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_data  <= 32'd0;
            wb_addr  <= 5'd0;
            wb_regWr <= 1'b0;
        end else begin
            wb_valid <= mem_valid;
            wb_data  <= mem_data;
            wb_addr  <= mem_addr;
            wb_regWr <= mem_regWr;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (load_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_source_pipe.sv
// tb_fwd_source_pipe: directed bench with a scoreboard for MEM and WB outputs.
// Expected ALUres_wb follows FWD_WB_BYPASS_EN as the DUT does.
module tb_fwd_source_pipe;

    localparam int W = 2;

    logic          clk;
    logic          reset;
    logic          ex_valid;
    logic [31:0]   ex_alu_res;
    logic [31:0]   ex_store_data;
    logic [4:0]    ex_wr_addr;
    logic          ex_regWr;
    logic          ex_memToReg;
    logic          ex_memWr;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [31:0]   dmem_rdata;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_we;
    logic [37:0]   ALUres_ex;
    logic [37:0]   ALUres_mem;
    logic [37:0]   ALUres_wb;
    logic [31:0]   dw;
    logic [4:0]    wr_addr;
    logic          wr_en;
    logic          load_stall;
    logic [W-1:0]  stall_count;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [37:0] b;
    } mexp_t;

    typedef struct {
        logic        en;
        logic [4:0]  a;
        logic [31:0] d;
    } wexp_t;

    mexp_t        mq[$];
    wexp_t        wq[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] sc_exp;

    fwd_source_pipe #(.STALL_CNT_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .ex_valid(ex_valid),
        .ex_alu_res(ex_alu_res),
        .ex_store_data(ex_store_data),
        .ex_wr_addr(ex_wr_addr),
        .ex_regWr(ex_regWr),
        .ex_memToReg(ex_memToReg),
        .ex_memWr(ex_memWr),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .dmem_rdata(dmem_rdata),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we),
        .ALUres_ex(ALUres_ex),
        .ALUres_mem(ALUres_mem),
        .ALUres_wb(ALUres_wb),
        .dw(dw),
        .wr_addr(wr_addr),
        .wr_en(wr_en),
        .load_stall(load_stall),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a == 32'h20) ? 32'hCAFE : (a ^ 32'hA5A5_0000);
    endfunction

    // Data memory model: read data is combinational on the address.
    always_comb dmem_rdata = rd(dmem_addr);

    task automatic chk(input string tag, input logic [37:0] obs,
                       input logic [37:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] wb_bundle(input wexp_t e);
`ifdef FWD_WB_BYPASS_EN
        return {e.en, e.a, e.d};
`else
        return 38'b0 | {37'b0, e.en & 1'b0};
`endif
    endfunction

    task automatic step(input logic v, input logic [31:0] res,
                        input logic [31:0] sd, input logic [4:0] wa,
                        input logic rw, input logic m2r, input logic mw,
                        input logic [4:0] rs, input logic [4:0] rt);
        logic  ew;
        logic  st;
        logic  l;
        mexp_t m;
        wexp_t w;
        @(negedge clk);
        ex_valid      = v;
        ex_alu_res    = res;
        ex_store_data = sd;
        ex_wr_addr    = wa;
        ex_regWr      = rw;
        ex_memToReg   = m2r;
        ex_memWr      = mw;
        id_rs         = rs;
        id_rt         = rt;
        #1;
        ew = v & rw & (wa != 5'd0);
        l  = v & m2r;
        st = ew & m2r & ((wa == rs) | (wa == rt));
        chk("ALUres_ex", ALUres_ex, {ew & ~m2r, wa, res});
        chk("load_stall", {37'b0, load_stall}, {37'b0, st});
        m.we = v & mw;
        m.a  = res;
        m.wd = sd;
        m.b  = {ew, wa, l ? rd(res) : res};
        mq.push_back(m);
        w.en = ew;
        w.a  = wa;
        w.d  = l ? rd(res) : res;
        wq.push_back(w);
        if (st && sc_exp != '1) sc_exp = sc_exp + 1'b1;
        @(posedge clk);
        #1;
        if (mq.size() == 0 || wq.size() == 0) begin
            chk("queue_empty", 38'd1, 38'd0);
        end else begin
            m = mq.pop_front();
            w = wq.pop_front();
            chk("dmem_we", {37'b0, dmem_we}, {37'b0, m.we});
            chk("dmem_addr", {6'b0, dmem_addr}, {6'b0, m.a});
            chk("dmem_wdata", {6'b0, dmem_wdata}, {6'b0, m.wd});
            chk("ALUres_mem", ALUres_mem, m.b);
            chk("wr_en", {37'b0, wr_en}, {37'b0, w.en});
            chk("wr_addr", {33'b0, wr_addr}, {33'b0, w.a});
            chk("dw", {6'b0, dw}, {6'b0, w.d});
            chk("ALUres_wb", ALUres_wb, wb_bundle(w));
        end
        chk("stall_count", {{(38-W){1'b0}}, stall_count},
            {{(38-W){1'b0}}, sc_exp});
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_alu_res    = 32'd0;
        ex_store_data = 32'd0;
        ex_wr_addr    = 5'd0;
        ex_regWr      = 1'b0;
        ex_memToReg   = 1'b0;
        ex_memWr      = 1'b0;
        id_rs         = 5'd0;
        id_rt         = 5'd0;
    endtask

    task automatic restart();
        wexp_t z;
        z.en = 1'b0;
        z.a  = 5'd0;
        z.d  = 32'd0;
        mq.delete();
        wq.delete();
        wq.push_back(z);
        sc_exp = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, {37'b0, dmem_we}, 38'd0);
        chk({tag, "_wr_en"}, {37'b0, wr_en}, 38'd0);
        chk({tag, "_dw"}, {6'b0, dw}, 38'd0);
        chk({tag, "_wr_addr"}, {33'b0, wr_addr}, 38'd0);
        chk({tag, "_dmem_addr"}, {6'b0, dmem_addr}, 38'd0);
        chk({tag, "_mem"}, ALUres_mem, {6'b0, rd(32'd0)} & 38'h0);
        chk({tag, "_wb"}, ALUres_wb, 38'd0);
        chk({tag, "_ex"}, ALUres_ex, 38'd0);
        chk({tag, "_cnt"}, {{(38-W){1'b0}}, stall_count}, 38'd0);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        sc_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        restart();

        // add $3 = 0x11, then bubbles to drain into WB
        step(1, 32'h11, 32'h0, 5'd3, 1, 0, 0, 5'd1, 5'd2);
        step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 5'd0, 5'd0);

        // lw $5 dependent reader in ID, then a bubble
        step(1, 32'h20, 32'h0, 5'd5, 1, 1, 0, 5'd5, 5'd9);
        step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 5'd5, 5'd9);

        // writes to $0: no forward, no write, no stall
        step(1, 32'h77, 32'h0, 5'd0, 1, 0, 0, 5'd0, 5'd0);
        step(1, 32'h24, 32'h0, 5'd0, 1, 1, 0, 5'd0, 5'd0);

        // sw 0x1234 -> 0x40
        step(1, 32'h40, 32'h1234, 5'd8, 0, 0, 1, 5'd8, 5'd8);

        // same destination in EX and MEM, load not hit by ID
        step(1, 32'h100, 32'h0, 5'd7, 1, 0, 0, 5'd1, 5'd1);
        step(1, 32'h200, 32'h0, 5'd7, 1, 0, 0, 5'd1, 5'd1);
        step(1, 32'h28, 32'h0, 5'd12, 1, 1, 0, 5'd1, 5'd2);

        // bubble carrying stale write/store flags
        step(0, 32'h300, 32'h55, 5'd9, 1, 0, 1, 5'd9, 5'd9);

        // add in WB and load in MEM when reset hits
        step(1, 32'h44, 32'h0, 5'd4, 1, 0, 0, 5'd0, 5'd0);
        step(1, 32'h24, 32'h0, 5'd9, 1, 1, 0, 5'd0, 5'd0);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        restart();

        // back-to-back load-use stalls, counter saturates
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h30 + 32'(i), 32'h0, 5'd6, 1, 1, 0, 5'd1, 5'd6);
        end
        step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 5'd0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
